ser_word_deserializer: RTL and testbench
========================================

// Module: ser_word_deserializer
// PURPOSE
//  Serial-in/parallel-out word receiver with a one-word output register and valid/ready handshakes.
//  It is the receive end of a serial link driven by a universal shift register (LS194-style).
//  The per-frame direction bit selects MSB-first (shift-left) or LSB-first (shift-right) assembly.
//  It sits between a serial bit source and a parallel word consumer in the 74-series emulation library.
// PARAMETERS
//  WIDTH   8   bits per frame = width of out_data (>=2)
// PORTS
//  clk        in   1      clock, all state updates on posedge
//  clr        in   1      reset, asynchronous, active-low
//  ser_valid  in   1      serial bit present on ser_data
//  ser_data   in   1      serial bit
//  ser_start  in   1      qualifies the accepted bit as first bit of a frame
//  ser_dir    in   1      sampled with start bit: 1 = shift left (first bit -> MSB), 0 = shift right (first bit -> LSB)
//  ser_ready  out  1      receiver accepts a bit this cycle
//  out_data   out  WIDTH  assembled word
//  out_valid  out  1      out_data holds an unconsumed word
//  out_ready  in   1      consumer takes word when out_valid & out_ready
//  frame_err  out  1      one-cycle registered pulse on framing error
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset (clr=0, async): state=IDLE, shift reg=0, bit count=0, dir=0, out_data=0, out_valid=0, frame_err=0.
//  - No bit is accepted while clr=0.
//  Bit accept = ser_valid & ser_ready.
//  ser_ready is combinational: 1 in IDLE and SHIFT, 0 in HOLD.
//  IDLE:
//  - Accepted bit with ser_start=1: latch ser_dir, load the bit as bit 1 of the frame (count=1), go to SHIFT.
//  - If WIDTH==1 is ever required, this is not supported (WIDTH>=2).
//  - Accepted bit with ser_start=0: drop it; frame_err=1 next cycle; stay IDLE.
//  SHIFT:
//  - Accepted bit, ser_start=0: dir=1 -> sr={sr[WIDTH-2:0],bit}; dir=0 -> sr={bit,sr[WIDTH-1:1]}; count++.
//  - Accepted bit, ser_start=1: frame_err pulse; abandon the partial frame.
//    The bit restarts the frame: count=1, dir re-latched.
//  - On acceptance of bit number WIDTH:
//    - If out_valid=0, or out_valid & out_ready this cycle: load out_data, set out_valid=1, go to IDLE.
//    - Otherwise go to HOLD with the word kept in the shift reg.
//  HOLD: ser_ready=0; when out_valid & out_ready, load the held word into out_data (out_valid stays 1), go to IDLE.
//  Output register:
//  - Handshake with no load in the same cycle clears out_valid.
//  - out_data is stable while out_valid & !out_ready.
//  Latency: WIDTH-th bit accepted at edge N -> out_valid=1 and out_data valid after edge N (no backpressure).
//  Throughput: one bit per clock; a new start bit may be accepted the cycle after the last bit of a frame.
//  Gaps (ser_valid=0) inside a frame are allowed; no timeout.
//  frame_err is exactly one cycle per error event, registered, never combinational.
//  Reset mid-frame or mid-HOLD: partial/held word is discarded, no out_valid afterwards.
// TESTING (WIDTH=8)
//  1. dir=1, bits 1,1,0,0,0,0,0,0 (start on first), out_ready=1
//     -> out_data=8'hC0, out_valid high for exactly 1 cycle, starting the cycle after bit 8.
//  2. Same bits, dir=0 -> out_data=8'h03; frame_err never asserted.
//  3. out_ready=0; send frame 8'h3C, then frame 8'h81 (dir=1)
//     -> ser_ready=0 after the 8th bit of 8'h81.
//     Then raise out_ready: 8'h3C handshakes, 8'h81 is presented the next cycle, ser_ready returns to 1.
//  4. 3 bits of a frame, then a new start bit followed by 7 bits forming 8'h5A
//     -> one frame_err pulse, out_data=8'h5A, only one out_valid.
//  5. In IDLE, ser_valid=1 with ser_start=0 for 2 cycles
//     -> two frame_err pulses, no out_valid, busy stays 0.
//  6. clr low after 4 bits of a frame; release; send 8'hE7
//     -> during reset all outputs are 0; afterwards out_data=8'hE7 with no stale bits.

Source files
------------

// File: rtl/ser_word_deserializer.sv
// Serial-in/parallel-out word receiver: assembles WIDTH-bit frames (MSB- or LSB-first)
// into a one-word output register, with a HOLD slot for a second word under backpressure.
module ser_word_deserializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             ser_valid,
   input  logic             ser_data,
   input  logic             ser_start,
   input  logic             ser_dir,
   output logic             ser_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             frame_err,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sr_q, sr_d;
   logic [WIDTH-1:0]   od_q, od_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               dir_q, dir_d;
   logic               ov_q, ov_d;
   logic               fe_q, fe_d;
   logic               accept;
   logic               hs;
   logic               load_out;

   // dir=1 pushes bits in at the LSB so the first bit ends up as MSB; dir=0 mirrors that.
   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr,
                                                 input logic b,
                                                 input logic dir);
      if (dir)
         return {sr[WIDTH-2:0], b};
      else
         return {b, sr[WIDTH-1:1]};
   endfunction

   assign accept = ser_valid & ser_ready;
   assign hs     = ov_q & out_ready;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= IDLE;
         sr_q    <= '0;
         od_q    <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         ov_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         od_q    <= od_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         ov_q    <= ov_d;
         fe_q    <= fe_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sr_d     = sr_q;
      od_d     = od_q;
      cnt_d    = cnt_q;
      dir_d    = dir_q;
      fe_d     = 1'b0;
      load_out = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (ser_start) begin
                  dir_d   = ser_dir;
                  sr_d    = shift_in('0, ser_data, ser_dir);
                  cnt_d   = CNT_W'(1);
                  state_d = SHIFT;
               end else begin
                  fe_d = 1'b1;
               end
            end
         end
         SHIFT: begin
            if (accept) begin
               if (ser_start) begin
                  // A start bit inside a frame abandons it and opens a fresh one.
                  fe_d    = 1'b1;
                  dir_d   = ser_dir;
                  sr_d    = shift_in('0, ser_data, ser_dir);
                  cnt_d   = CNT_W'(1);
               end else begin
                  sr_d = shift_in(sr_q, ser_data, dir_q);
                  if (cnt_q == CNT_W'(WIDTH - 1)) begin
                     cnt_d = '0;
                     if (!ov_q || hs) begin
                        od_d     = sr_d;
                        load_out = 1'b1;
                        state_d  = IDLE;
                     end else begin
                        state_d = HOLD;
                     end
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
         end
         HOLD: begin
            if (hs) begin
               od_d     = sr_q;
               load_out = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      if (load_out)
         ov_d = 1'b1;
      else if (hs)
         ov_d = 1'b0;
      else
         ov_d = ov_q;
   end

   always_comb begin
      ser_ready = clr & (state_q != HOLD);
      busy      = (state_q != IDLE);
      out_data  = od_q;
      out_valid = ov_q;
      frame_err = fe_q;
   end

endmodule

// File: tb/tb_ser_word_deserializer.sv
// Bench for ser_word_deserializer: directed scenarios plus random traffic, all checked
// every cycle against a frame/queue-level reference model.
module tb_ser_word_deserializer;

   localparam int W = 8;

   logic         clk;
   logic         clr;
   logic         ser_valid;
   logic         ser_data;
   logic         ser_start;
   logic         ser_dir;
   logic         ser_ready;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_ready;
   logic         frame_err;
   logic         busy;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model: bits of the frame being received, output slot, held word
   bit           m_inframe;
   bit           m_dir;
   bit           m_bits[$];
   bit           m_ov;
   logic [W-1:0] m_od;
   bit           m_held;
   logic [W-1:0] m_hw;
   bit           m_fe;

   ser_word_deserializer #(.WIDTH(W)) dut (
      .clk       (clk),
      .clr       (clr),
      .ser_valid (ser_valid),
      .ser_data  (ser_data),
      .ser_start (ser_start),
      .ser_dir   (ser_dir),
      .ser_ready (ser_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   function automatic logic [W-1:0] assemble(input bit dir);
      logic [W-1:0] w = '0;
      for (int i = 0; i < W; i++) begin
         if (dir) w[W-1-i] = m_bits[i];
         else     w[i]     = m_bits[i];
      end
      return w;
   endfunction

   task automatic model_reset();
      m_inframe = 0; m_dir = 0; m_bits.delete();
      m_ov = 0; m_od = '0; m_held = 0; m_hw = '0; m_fe = 0;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".out_valid"}, out_valid, m_ov);
      chk({tag, ".out_data"},  out_data,  m_od);
      chk({tag, ".frame_err"}, frame_err, m_fe);
      chk({tag, ".busy"},      busy,      m_inframe || m_held);
   endtask

   task automatic step(input logic sv, input logic sd, input logic ss,
                       input logic sdir, input logic ordy);
      bit ready, accept, hs, load;
      @(negedge clk);
      ser_valid = sv; ser_data = sd; ser_start = ss; ser_dir = sdir; out_ready = ordy;
      #1;
      ready = clr && !m_held;
      chk("ser_ready", ser_ready, ready);
      @(posedge clk);
      accept = sv && ready;
      hs     = m_ov && ordy;
      load   = 0;
      m_fe   = 0;
      if (m_held) begin
         if (hs) begin
            m_od = m_hw; m_held = 0; load = 1;
         end
      end else if (accept) begin
         if (ss) begin
            m_fe = m_inframe;
            m_bits.delete();
            m_bits.push_back(sd);
            m_dir = sdir;
            m_inframe = 1;
         end else if (!m_inframe) begin
            m_fe = 1;
         end else begin
            m_bits.push_back(sd);
            if (m_bits.size() == W) begin
               m_inframe = 0;
               if (!m_ov || hs) begin
                  m_od = assemble(m_dir); load = 1;
               end else begin
                  m_hw = assemble(m_dir); m_held = 1;
               end
               m_bits.delete();
            end
         end
      end
      if (load) m_ov = 1;
      else if (hs) m_ov = 0;
      #1;
      check_outputs("cyc");
   endtask

   task automatic send_frame(input logic [W-1:0] word, input logic dir, input logic ordy);
      for (int i = 0; i < W; i++)
         step(1'b1, dir ? word[W-1-i] : word[i], (i == 0), dir, ordy);
   endtask

   task automatic idle(input int n, input logic ordy);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, ordy);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ".ser_ready"}, ser_ready, 0);
      chk({tag, ".out_valid"}, out_valid, 0);
      chk({tag, ".out_data"},  out_data,  0);
      chk({tag, ".frame_err"}, frame_err, 0);
      chk({tag, ".busy"},      busy,      0);
   endtask

   initial begin
      int fe_cnt;
      clr = 1'b0; ser_valid = 0; ser_data = 0; ser_start = 0; ser_dir = 0; out_ready = 0;
      model_reset();
      #3;
      check_all_zero("reset");
      @(negedge clk);
      clr = 1'b1;

      // 1: MSB-first 1,1,0..0 -> C0, valid for one cycle
      send_frame(8'hC0, 1'b1, 1'b1);
      chk("t1.data", out_data, 8'hC0);
      chk("t1.valid", out_valid, 1);
      idle(1, 1'b1);
      chk("t1.valid_gone", out_valid, 0);

      // 2: LSB-first same bit sequence -> 03
      send_frame(8'h03, 1'b0, 1'b1);
      chk("t2.data", out_data, 8'h03);
      idle(1, 1'b1);

      // 3: backpressure: second frame parks in HOLD
      send_frame(8'h3C, 1'b1, 1'b0);
      send_frame(8'h81, 1'b1, 1'b0);
      chk("t3.ready_low", ser_ready, 0);
      chk("t3.first", out_data, 8'h3C);
      idle(1, 1'b1);
      chk("t3.second", out_data, 8'h81);
      chk("t3.ready_back", ser_ready, 1);
      idle(2, 1'b1);

      // 4: abandoned partial frame then a full 5A
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      fe_cnt = 0;
      for (int i = 0; i < W; i++) begin
         step(1'b1, 8'h5A >> (W-1-i), (i == 0), 1'b1, 1'b1);
         if (frame_err) fe_cnt++;
      end
      chk("t4.fe_pulses", fe_cnt, 1);
      chk("t4.data", out_data, 8'h5A);
      idle(2, 1'b1);

      // 5: stray bits in IDLE
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("t5.fe1", frame_err, 1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t5.fe2", frame_err, 1);
      idle(1, 1'b1);

      // 6: reset in mid-frame
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, (i == 0), 1'b1, 1'b1);
      @(negedge clk);
      clr = 1'b0;
      ser_valid = 1'b1; ser_start = 1'b0;
      #1;
      model_reset();
      check_all_zero("t6.in_reset");
      @(negedge clk);
      #1;
      check_all_zero("t6.in_reset2");
      clr = 1'b1;
      ser_valid = 1'b0;
      send_frame(8'hE7, 1'b1, 1'b1);
      chk("t6.data", out_data, 8'hE7);
      idle(1, 1'b1);

      // random traffic
      for (int i = 0; i < 3000; i++)
         step(($urandom % 4) != 0, $urandom % 2, ($urandom % 10) == 0,
              $urandom % 2, ($urandom % 4) != 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
